// File: rtl/tama_pkg.sv
// Shared types and constants for the tamagotchi status pipeline.
// Action codes, life states, need indices and action deltas.
package tama_pkg;

    localparam int CNT_W   = 16;
    localparam int N_NEEDS = 6;

    localparam int N_HUNGER  = 0;
    localparam int N_HAPPY   = 1;
    localparam int N_HEALTH  = 2;
    localparam int N_HYGIENE = 3;
    localparam int N_ENERGY  = 4;
    localparam int N_SOCIAL  = 5;

    localparam logic [2:0] ACT_FEED     = 3'd0;
    localparam logic [2:0] ACT_PLAY     = 3'd1;
    localparam logic [2:0] ACT_CLEAN    = 3'd2;
    localparam logic [2:0] ACT_MEDICINE = 3'd3;
    localparam logic [2:0] ACT_SLEEP    = 3'd4;
    localparam logic [2:0] ACT_WAKE     = 3'd5;

    localparam logic [4:0] LEVEL_MAX = 5'd31;

    localparam logic signed [6:0] D_FEED_HUNGER  = 7'sd8;
    localparam logic signed [6:0] D_FEED_HYGIENE = 7'sd2;
    localparam logic signed [6:0] D_PLAY_HAPPY   = 7'sd6;
    localparam logic signed [6:0] D_PLAY_SOCIAL  = 7'sd4;
    localparam logic signed [6:0] D_PLAY_ENERGY  = 7'sd3;
    localparam logic signed [6:0] D_CLEAN        = 7'sd10;
    localparam logic signed [6:0] D_MED_HEALTH   = 7'sd8;
    localparam logic signed [6:0] D_MED_HAPPY    = 7'sd2;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_ASLEEP = 2'd1,
        ST_DEAD   = 2'd2
    } life_e;

endpackage

// File: rtl/need_counter.sv
// One need: tick-driven rate counter plus a saturating 0..31 level.
// The action/coupling delta and the own decay are merged in one update.
module need_counter
    import tama_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_tick,
    input  logic                    i_freeze,
    input  logic [CNT_W-1:0]        i_rate,
    input  logic signed [6:0]       i_delta,
    output logic [4:0]              o_level,
    output logic [4:0]              o_level_nxt
);

    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_level;
    logic              w_adv;
    logic              w_wrap;
    logic signed [6:0] w_sum;

    assign w_adv  = i_tick && !i_freeze;
    assign w_wrap = w_adv && (r_cnt == i_rate - CNT_W'(1));
    assign w_sum  = signed'({2'b00, r_level}) + i_delta
                  + signed'({6'b000000, w_wrap});

    always_comb begin
        o_level_nxt = r_level;
        if (w_sum[6])
            o_level_nxt = 5'd0;
        else if (w_sum > 7'sd31)
            o_level_nxt = LEVEL_MAX;
        else
            o_level_nxt = w_sum[4:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= '0;
        end else begin
            r_level <= o_level_nxt;
            if (w_adv)
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/needs_engine.sv
// Need levels, game-tick prescaler, action handshake and life-state FSM.
// Level registers live in six need_counter instances.
module needs_engine
    import tama_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int HUNGER_RATE = 4,
    parameter int HAPPY_RATE  = 6,
    parameter int HEALTH_RATE = 16,
    parameter int HYGIENE_RATE = 8,
    parameter int ENERGY_RATE = 5,
    parameter int SOCIAL_RATE = 10,
    parameter int SICK_THRESH = 24
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       action_valid,
    input  logic [2:0] action_code,
    output logic       action_ready,
    output logic       action_err,
    output logic [4:0] hunger,
    output logic [4:0] happiness,
    output logic [4:0] health,
    output logic [4:0] hygiene,
    output logic [4:0] energy,
    output logic [4:0] social,
    output logic       asleep,
    output logic       alive,
    output logic       tick
);

    localparam logic [CNT_W-1:0] RATES [N_NEEDS] = '{
        CNT_W'(HUNGER_RATE), CNT_W'(HAPPY_RATE),
        CNT_W'(HEALTH_RATE), CNT_W'(HYGIENE_RATE),
        CNT_W'(ENERGY_RATE), CNT_W'(SOCIAL_RATE)
    };

    life_e             r_state;
    logic [31:0]       r_pre;
    logic              r_tick;
    logic              r_err;

    logic              w_accept;
    logic              w_err;
    logic              w_sleep;
    logic              w_wake;
    logic              w_sick;
    logic              w_die;
    logic              w_asleep;
    logic [N_NEEDS-1:0] w_freeze;
    logic signed [6:0] w_delta   [N_NEEDS];
    logic [4:0]        w_lvl     [N_NEEDS];
    logic [4:0]        w_lvl_nxt [N_NEEDS];

    assign w_asleep = (r_state == ST_ASLEEP);
    assign action_ready = (r_state != ST_DEAD);
    assign w_accept = action_valid && action_ready;

    // Sick check uses the levels before this cycle's update.
    assign w_sick = r_tick &&
                    ((w_lvl[N_HUNGER]  >= 5'(SICK_THRESH)) ||
                     (w_lvl[N_HYGIENE] >= 5'(SICK_THRESH)));

    assign w_die = (r_state != ST_DEAD) &&
                   ((w_lvl[N_HUNGER] == LEVEL_MAX) ||
                    (w_lvl[N_HEALTH] == LEVEL_MAX));

    always_comb begin
        for (int i = 0; i < N_NEEDS; i++)
            w_delta[i] = '0;
        w_err   = 1'b0;
        w_sleep = 1'b0;
        w_wake  = 1'b0;
        if (w_accept) begin
            if (action_code > ACT_WAKE) begin
                w_err = 1'b1;
            end else if (w_asleep) begin
                if (action_code == ACT_WAKE)
                    w_wake = 1'b1;
                else
                    w_err = 1'b1;
            end else begin
                unique case (action_code)
                    ACT_FEED: begin
                        w_delta[N_HUNGER]  = -D_FEED_HUNGER;
                        w_delta[N_HYGIENE] = D_FEED_HYGIENE;
                    end
                    ACT_PLAY: begin
                        w_delta[N_HAPPY]  = -D_PLAY_HAPPY;
                        w_delta[N_SOCIAL] = -D_PLAY_SOCIAL;
                        w_delta[N_ENERGY] = D_PLAY_ENERGY;
                    end
                    ACT_CLEAN:    w_delta[N_HYGIENE] = -D_CLEAN;
                    ACT_MEDICINE: begin
                        w_delta[N_HEALTH] = -D_MED_HEALTH;
                        w_delta[N_HAPPY]  = D_MED_HAPPY;
                    end
                    ACT_SLEEP: w_sleep = 1'b1;
                    default: ;
                endcase
            end
        end
        if (w_sick)
            w_delta[N_HEALTH] = w_delta[N_HEALTH] + 7'sd1;
        if (w_asleep && r_tick)
            w_delta[N_ENERGY] = w_delta[N_ENERGY] - 7'sd1;
    end

    always_comb begin
        w_freeze = '0;
        if (w_asleep) begin
            w_freeze[N_HAPPY]   = 1'b1;
            w_freeze[N_HYGIENE] = 1'b1;
            w_freeze[N_ENERGY]  = 1'b1;
            w_freeze[N_SOCIAL]  = 1'b1;
        end
    end

    for (genvar g = 0; g < N_NEEDS; g++) begin : g_need
        need_counter u_need (
            .clk         (clk),
            .reset       (reset),
            .i_tick      (r_tick),
            .i_freeze    (w_freeze[g]),
            .i_rate      (RATES[g]),
            .i_delta     (w_delta[g]),
            .o_level     (w_lvl[g]),
            .o_level_nxt (w_lvl_nxt[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_AWAKE;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (r_state == ST_DEAD || w_die) begin
                r_tick <= 1'b0;
            end else if (r_pre == 32'(TICK_DIV - 1)) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pre  <= r_pre + 32'd1;
                r_tick <= 1'b0;
            end
            // Death outranks wake, auto-wake and sleep.
            if (w_die)
                r_state <= ST_DEAD;
            else if (w_asleep && (w_wake || w_lvl_nxt[N_ENERGY] == 5'd0))
                r_state <= ST_AWAKE;
            else if (r_state == ST_AWAKE && w_sleep)
                r_state <= ST_ASLEEP;
        end
    end

    assign action_err = r_err;
    assign tick       = r_tick;
    assign asleep     = w_asleep;
    assign alive      = (r_state != ST_DEAD);

    assign hunger    = w_lvl[N_HUNGER];
    assign happiness = w_lvl[N_HAPPY];
    assign health    = w_lvl[N_HEALTH];
    assign hygiene   = w_lvl[N_HYGIENE];
    assign energy    = w_lvl[N_ENERGY];
    assign social    = w_lvl[N_SOCIAL];

endmodule

// File: tb/tb_needs_engine.sv
// Directed bench for needs_engine: cycle table plus multi-cycle sequences.
// TICK_DIV=4 and every rate 1, so each tick ages every running need by one.
module tb_needs_engine;

    logic       clk;
    logic       reset;
    logic       action_valid;
    logic [2:0] action_code;
    logic       action_ready;
    logic       action_err;
    logic [4:0] hunger, happiness, health, hygiene, energy, social;
    logic       asleep, alive, tick;

    int n_run;
    int n_fail;

    needs_engine #(
        .TICK_DIV(4), .HUNGER_RATE(1), .HAPPY_RATE(1), .HEALTH_RATE(1),
        .HYGIENE_RATE(1), .ENERGY_RATE(1), .SOCIAL_RATE(1), .SICK_THRESH(24)
    ) dut (
        .clk(clk), .reset(reset),
        .action_valid(action_valid), .action_code(action_code),
        .action_ready(action_ready), .action_err(action_err),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .asleep(asleep), .alive(alive), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] c;
        int hu, ha, he, hy, en, so;
        logic asl, err, tck;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [2:0] c);
        action_valid = v;
        action_code  = c;
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        action_code  = 3'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 3'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " hunger"}, hunger, 0);
        chk({tag, " happiness"}, happiness, 0);
        chk({tag, " health"}, health, 0);
        chk({tag, " hygiene"}, hygiene, 0);
        chk({tag, " energy"}, energy, 0);
        chk({tag, " social"}, social, 0);
        chk({tag, " alive"}, alive, 1);
        chk({tag, " ready"}, action_ready, 1);
        chk({tag, " asleep"}, asleep, 0);
        chk({tag, " err"}, action_err, 0);
        chk({tag, " tick"}, tick, 0);
    endtask

    task automatic do_reset();
        action_valid = 1'b0;
        action_code  = 3'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        action_valid = 1'b0;
        action_code  = 3'd0;

        tbl[0]  = '{1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd0, 0, 0, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd1, 0, 0, 0, 2, 3, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 0, 0, 0, 2, 3, 0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 3'd2, 1, 1, 1, 0, 4, 1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd7, 1, 1, 1, 0, 4, 1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 1, 1, 1, 0, 4, 1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd3, 1, 3, 0, 0, 4, 1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 3'd4, 2, 4, 1, 1, 5, 2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd0, 2, 4, 1, 1, 5, 2, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 2, 4, 1, 1, 5, 2, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 2, 4, 1, 1, 5, 2, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 3'd0, 3, 4, 2, 1, 4, 2, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'd5, 3, 4, 2, 1, 4, 2, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 3'd5, 3, 4, 2, 1, 4, 2, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 3'd0, 3, 4, 2, 1, 4, 2, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 3'd0, 4, 5, 3, 2, 5, 3, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;

        // Table: one row per cycle from reset release.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].v, tbl[i].c);
            chk($sformatf("t%0d hunger", i), hunger, tbl[i].hu);
            chk($sformatf("t%0d happiness", i), happiness, tbl[i].ha);
            chk($sformatf("t%0d health", i), health, tbl[i].he);
            chk($sformatf("t%0d hygiene", i), hygiene, tbl[i].hy);
            chk($sformatf("t%0d energy", i), energy, tbl[i].en);
            chk($sformatf("t%0d social", i), social, tbl[i].so);
            chk($sformatf("t%0d asleep", i), asleep, tbl[i].asl);
            chk($sformatf("t%0d err", i), action_err, tbl[i].err);
            chk($sformatf("t%0d tick", i), tick, tbl[i].tck);
            chk($sformatf("t%0d alive", i), alive, 1);
            chk($sformatf("t%0d ready", i), action_ready, 1);
        end

        // FEED clamps hunger 5 to 0.
        do_reset();
        idle(21);
        chk("A hunger pre", hunger, 5);
        cyc(1'b1, 3'd0);
        chk("A hunger clamp", hunger, 0);
        chk("A hygiene", hygiene, 7);

        // FEED coincident with a tick at hunger 20.
        do_reset();
        idle(84);
        chk("B tick", tick, 1);
        chk("B hunger pre", hunger, 20);
        cyc(1'b1, 3'd0);
        chk("B hunger", hunger, 13);
        chk("B hygiene", hygiene, 23);
        chk("B health", health, 21);

        // Medicine keeps health low; sick coupling, then death by hunger.
        do_reset();
        idle(81);
        cyc(1'b1, 3'd3);
        cyc(1'b1, 3'd3);
        chk("D health med", health, 4);
        chk("D happy med", happiness, 24);
        idle(14);
        chk("D hunger 24", hunger, 24);
        chk("D health pre sick", health, 8);
        idle(4);
        chk("D health sick", health, 10);
        idle(24);
        chk("D hunger max", hunger, 31);
        chk("D health", health, 22);
        idle(1);
        chk("D alive", alive, 0);
        chk("D ready", action_ready, 0);
        chk("D asleep", asleep, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 3'd0);
            chk("D frozen hunger", hunger, 31);
            chk("D frozen health", health, 22);
            chk("D dead tick", tick, 0);
            chk("D dead err", action_err, 0);
        end

        // Sleep at energy 3, FEED rejected, auto-wake at energy 0.
        do_reset();
        idle(13);
        chk("E energy pre", energy, 3);
        cyc(1'b1, 3'd4);
        chk("E asleep", asleep, 1);
        cyc(1'b1, 3'd0);
        chk("E feed err", action_err, 1);
        chk("E feed hunger", hunger, 3);
        idle(2);
        chk("E err clear", action_err, 0);
        chk("E energy 2", energy, 2);
        chk("E hunger 4", hunger, 4);
        chk("E hygiene frozen", hygiene, 3);
        chk("E social frozen", social, 3);
        idle(4);
        chk("E energy 1", energy, 1);
        chk("E still asleep", asleep, 1);
        idle(4);
        chk("E energy 0", energy, 0);
        chk("E auto wake", asleep, 0);
        chk("E hunger 6", hunger, 6);
        chk("E hygiene held", hygiene, 3);

        // Async reset during a pending PLAY and an active tick.
        do_reset();
        idle(20);
        chk("F tick pre", tick, 1);
        chk("F hunger pre", hunger, 4);
        action_valid = 1'b1;
        action_code  = 3'd1;
        #3;
        reset = 1'b1;
        #1;
        chk_zero("F async");
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        action_code  = 3'd0;
        reset = 1'b0;
        idle(1);
        chk_zero("F release");
        idle(3);
        chk("F first tick", tick, 1);
        chk("F energy", energy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
